// File: rtl/flat_vec_stream_reader_pkg.sv
// Shared definitions for clients of the coprocessor flat result RAM.
package flat_vec_stream_reader_pkg;

  // Readback sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } rd_state_e;

  // Limit a requested word count to the number of words in the vector.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/flat_vec_stream_reader.sv
// Snapshots a flattened DEPTH*WIDTH RAM image on start and streams words
// 0..len-1 out on a valid/ready interface with index and last markers.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; snapshot and length are loaded on accept
// STREAM | presenting snapshot words in address order, one per handshake
// FINISH | single cycle with done high, then back to IDLE
module flat_vec_stream_reader
  import flat_vec_stream_reader_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int LW = $clog2(DEPTH + 1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [LW-1:0]          len,
  input  logic [DEPTH*WIDTH-1:0] flat_din,
  output logic                   busy,
  output logic                   done,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic [IW-1:0]          m_index,
  output logic                   m_last
);

  rd_state_e              state;
  rd_state_e              state_nxt;
  logic [DEPTH*WIDTH-1:0] snapshot;
  logic [LW-1:0]          len_q;
  logic [LW-1:0]          len_c;
  logic [IW-1:0]          idx;
  logic                   accept;
  logic                   beat;

  assign len_c  = LW'(clamp_len(32'(len), 32'(DEPTH)));
  assign accept = (state == IDLE) && start;
  assign beat   = m_valid && m_ready;

  // Word mux: the current index selects straight out of the frozen snapshot.
  assign m_data  = snapshot[idx*WIDTH +: WIDTH];
  assign m_index = idx;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake/status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len_c == '0) ? FINISH : STREAM;
      end
      STREAM: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        m_last  = (LW'(idx) == (len_q - LW'(1)));
        if (m_ready && m_last) state_nxt = FINISH;
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot, length and index: loaded on accept, index advances per beat.
  // The index stops on the last beat, so it never wraps past len-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snapshot <= '0;
      len_q    <= '0;
      idx      <= '0;
    end else if (accept) begin
      snapshot <= flat_din;
      len_q    <= len_c;
      idx      <= '0;
    end else if (beat && !m_last) begin
      idx <= idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_flat_vec_stream_reader.sv
// Bench for flat_vec_stream_reader with WIDTH=8, DEPTH=4.
module tb_flat_vec_stream_reader;
  localparam int W = 8;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    len;
  logic [31:0]   flat_din;
  logic          busy;
  logic          done;
  logic          m_valid;
  logic          m_ready;
  logic [7:0]    m_data;
  logic [1:0]    m_index;
  logic          m_last;

  int checks   = 0;
  int failures = 0;

  flat_vec_stream_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len),
    .flat_din (flat_din),
    .busy     (busy),
    .done     (done),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),    0);
    chk({tag, "_done"},  32'(done),    0);
    chk({tag, "_valid"}, 32'(m_valid), 0);
    chk({tag, "_last"},  32'(m_last),  0);
    chk({tag, "_data"},  32'(m_data),  0);
    chk({tag, "_index"}, 32'(m_index), 0);
  endtask

  // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
  // glitch: change flat_din right after accept. poke: hold start high and
  // alter len/flat_din throughout the stream and the done cycle.
  task automatic run(input logic [31:0] din, input int ln, input int mode,
                     input bit glitch, input bit poke);
    logic [7:0] exp_q[$];
    int  n;
    int  k;
    int  budget;
    int  phase;
    bit  r;
    n = (ln > D) ? D : ln;
    for (int i = 0; i < n; i++) exp_q.push_back(din[i*W +: W]);
    chk("pre_idle_busy", 32'(busy), 0);
    start    = 1'b1;
    len      = ln[2:0];
    flat_din = din;
    m_ready  = 1'b0;
    step();
    start = 1'b0;
    if (glitch) flat_din = 32'hDDCCBBAA;
    if (n == 0) begin
      chk("len0_valid", 32'(m_valid), 0);
      chk("len0_busy",  32'(busy),    0);
      chk("len0_done",  32'(done),    1);
      step();
      chk("len0_done_clear", 32'(done), 0);
      chk("len0_valid_after", 32'(m_valid), 0);
      return;
    end
    k      = 0;
    budget = 0;
    phase  = 0;
    while (k < n && budget < 200) begin
      chk("beat_valid", 32'(m_valid), 1);
      chk("beat_busy",  32'(busy),    1);
      chk("beat_done",  32'(done),    0);
      chk("beat_data",  32'(m_data),  32'(exp_q[k]));
      chk("beat_index", 32'(m_index), 32'(k));
      chk("beat_last",  32'(m_last),  32'(k == n - 1));
      case (mode)
        0:       r = 1'b1;
        1:       r = ((phase % 4) == 0) || ((phase % 4) == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      phase++;
      m_ready = r;
      if (poke) begin
        start    = 1'b1;
        len      = 3'd1;
        flat_din = 32'hDDCCBBAA;
      end
      step();
      budget++;
      if (r) k++;
    end
    chk("beats_within_budget", 32'(k), 32'(n));
    m_ready = 1'b0;
    chk("fin_valid", 32'(m_valid), 0);
    chk("fin_busy",  32'(busy),    0);
    chk("fin_done",  32'(done),    1);
    chk("fin_last",  32'(m_last),  0);
    step();
    start = 1'b0;
    chk("post_done",  32'(done),    0);
    chk("post_valid", 32'(m_valid), 0);
    chk("post_busy",  32'(busy),    0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    len      = 3'd0;
    flat_din = 32'h0;
    m_ready  = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk_all_zero("reset");

    run(32'h44332211, 4, 0, 1'b0, 1'b0);
    run(32'h44332211, 4, 1, 1'b0, 1'b0);
    run(32'h44332211, 4, 0, 1'b1, 1'b0);
    run(32'h44332211, 0, 0, 1'b0, 1'b0);
    run(32'h44332211, 7, 0, 1'b0, 1'b0);
    run(32'h44332211, 4, 2, 1'b0, 1'b1);
    run(32'h44332211, 1, 0, 1'b0, 1'b0);

    // Abort mid-stream with reset, then restart from index 0.
    start    = 1'b1;
    len      = 3'd4;
    flat_din = 32'h44332211;
    m_ready  = 1'b1;
    step();
    start = 1'b0;
    chk("abort_beat0_data", 32'(m_data), 32'h11);
    step();
    chk("abort_beat1_index", 32'(m_index), 1);
    rst_n   = 1'b0;
    m_ready = 1'b0;
    step();
    rst_n = 1'b1;
    chk_all_zero("abort");
    step();
    chk("abort_no_done", 32'(done), 0);
    run(32'h44332211, 4, 0, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run($urandom, int'($urandom_range(0, 7)), 2, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
